// File: rtl/opnd_stage.sv
// Operand-fetch stage: register file with write bypass, single-entry
// registered operand pair with valid/ready handshake, and ALU flag register.
module opnd_stage #(
  parameter int unsigned W = 8,
  parameter int unsigned A = 3
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         IssueValid,
  output logic         IssueReady,
  input  logic [A-1:0] RdAddrA,
  input  logic [A-1:0] RdAddrB,
  input  logic         ImmSel,
  input  logic [W-1:0] Imm,
  output logic         OpValid,
  input  logic         OpReady,
  output logic [W-1:0] InputA,
  output logic [W-1:0] InputB,
  input  logic         WrEn,
  input  logic [A-1:0] WrAddr,
  input  logic [W-1:0] WrData,
  input  logic         FlagEn,
  input  logic         ZeroIn,
  input  logic         ParityIn,
  input  logic         OddIn,
  output logic         Zero,
  output logic         Parity,
  output logic         Odd
);

  localparam int unsigned NREG = 1 << A;
  localparam int unsigned NFLG = 3;

  logic [W-1:0]    rf_q [NREG];
  logic [W-1:0]    rf_d [NREG];
  logic            op_valid_q, op_valid_d;
  logic [W-1:0]    input_a_q, input_a_d;
  logic [W-1:0]    input_b_q, input_b_d;
  logic [NFLG-1:0] flags_q, flags_d;

  logic [W-1:0]    src_a;
  logic [W-1:0]    src_b;
  logic            issue_acc;

  // Single entry may accept whenever it is empty or being drained this cycle.
  assign IssueReady = !op_valid_q || OpReady;

  // Source operand read: R0 is zero, otherwise same-cycle writeback wins over the array.
  always_comb begin
    src_a = rf_q[RdAddrA];
    if (WrEn && (WrAddr == RdAddrA)) src_a = WrData;
    if (RdAddrA == '0)               src_a = '0;
    src_b = rf_q[RdAddrB];
    if (WrEn && (WrAddr == RdAddrB)) src_b = WrData;
    if (RdAddrB == '0)               src_b = '0;
  end

  // Register file update; writes to R0 are discarded.
  always_comb begin
    rf_d = rf_q;
    if (WrEn && (WrAddr != '0)) rf_d[WrAddr] = WrData;
  end

  // Operand pair: load on accept, drop valid on drain, otherwise hold (stall keeps sampled values).
  always_comb begin
    op_valid_d = op_valid_q;
    input_a_d  = input_a_q;
    input_b_d  = input_b_q;
    issue_acc  = IssueValid && IssueReady;
    if (issue_acc) begin
      op_valid_d = 1'b1;
      input_a_d  = src_a;
      input_b_d  = ImmSel ? Imm : src_b;
    end else if (op_valid_q && OpReady) begin
      op_valid_d = 1'b0;
    end
  end

  // Flag capture, independent of the operand handshake.
  always_comb begin
    flags_d = flags_q;
    if (FlagEn) flags_d = {ZeroIn, ParityIn, OddIn};
  end

  // State registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
      op_valid_q <= 1'b0;
      input_a_q  <= '0;
      input_b_q  <= '0;
      flags_q    <= '0;
    end else begin
      rf_q       <= rf_d;
      op_valid_q <= op_valid_d;
      input_a_q  <= input_a_d;
      input_b_q  <= input_b_d;
      flags_q    <= flags_d;
    end
  end

  assign OpValid = op_valid_q;
  assign InputA  = input_a_q;
  assign InputB  = input_b_q;
  assign Zero    = flags_q[2];
  assign Parity  = flags_q[1];
  assign Odd     = flags_q[0];

endmodule

// File: tb/tb_opnd_stage.sv
// Bench for opnd_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_opnd_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iv, ordy, isel, we, fe, zi, pi, oi;
  logic [2:0] ra, rb, wa;
  logic [7:0] imm, wd;
  logic       issue_ready, op_valid, zero, parity, odd;
  logic [7:0] in_a, in_b;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [7:0] mrf [8];
  logic       mv;
  logic [7:0] ma, mb;
  logic [2:0] mflags;

  always #5 clk = ~clk;

  opnd_stage dut (
    .Clk(clk), .Reset_n(rst_n),
    .IssueValid(iv), .IssueReady(issue_ready),
    .RdAddrA(ra), .RdAddrB(rb), .ImmSel(isel), .Imm(imm),
    .OpValid(op_valid), .OpReady(ordy),
    .InputA(in_a), .InputB(in_b),
    .WrEn(we), .WrAddr(wa), .WrData(wd),
    .FlagEn(fe), .ZeroIn(zi), .ParityIn(pi), .OddIn(oi),
    .Zero(zero), .Parity(parity), .Odd(odd)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
  endtask

  function automatic logic [7:0] model_src(input logic [2:0] x);
    if (x == 3'd0) return 8'h00;
    if (we && wa == x) return wd;
    return mrf[x];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mrf[i] = 8'h00;
    mv = 1'b0; ma = 8'h00; mb = 8'h00; mflags = 3'b000;
  endtask

  task automatic idle();
    iv = 0; ordy = 1; isel = 0; we = 0; fe = 0; zi = 0; pi = 0; oi = 0;
    ra = 0; rb = 0; wa = 0; imm = 0; wd = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, 8'(op_valid), 8'(mv));
    chk({tag, "_a"}, in_a, ma);
    chk({tag, "_b"}, in_b, mb);
    chk({tag, "_flags"}, 8'({zero, parity, odd}), 8'(mflags));
  endtask

  // One clock: inputs already driven; check ready, advance model, check registered outputs.
  task automatic step(input string tag);
    logic       acc;
    logic [7:0] na, nb;
    #1;
    chk({tag, "_ready"}, 8'(issue_ready), 8'(!mv || ordy));
    acc = iv && (!mv || ordy);
    na  = model_src(ra);
    nb  = isel ? imm : model_src(rb);
    @(posedge clk);
    #1;
    if (acc) begin
      mv = 1'b1; ma = na; mb = nb;
    end else if (mv && ordy) begin
      mv = 1'b0;
    end
    if (we && wa != 3'd0) mrf[wa] = wd;
    if (fe) mflags = {zi, pi, oi};
    check_outputs(tag);
  endtask

  // Asynchronous reset pulse away from the clock edge.
  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #2;
    model_clear();
    idle();
    #1;
    check_outputs(tag);
    chk({tag, "_ready"}, 8'(issue_ready), 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    model_clear();
    rst_n = 1'b1;
    #1;
    reset_pulse("por");

    // write R3, R5 on separate cycles
    idle(); we = 1; wa = 3; wd = 8'h5A; step("wr_r3");
    idle(); we = 1; wa = 5; wd = 8'hC3; step("wr_r5");
    idle(); iv = 1; ra = 3; rb = 5; step("rd_35");
    chk("rd_35_a_const", in_a, 8'h5A);
    chk("rd_35_b_const", in_b, 8'hC3);

    // stall with writeback to a captured register
    idle(); ordy = 0; we = 1; wa = 3; wd = 8'h99; step("stall");
    chk("stall_ready_low", 8'(issue_ready), 8'h00);
    chk("stall_a_held", in_a, 8'h5A);

    // release with new issue same edge, plus bypass of R2 and R0 read
    idle(); iv = 1; ra = 2; rb = 0; we = 1; wa = 2; wd = 8'h77; step("b2b_bypass");
    chk("bypass_a_const", in_a, 8'h77);
    chk("bypass_b_const", in_b, 8'h00);
    chk("b2b_valid_const", 8'(op_valid), 8'h01);

    idle(); step("drain");
    chk("drain_valid_const", 8'(op_valid), 8'h00);

    // R0 write discarded
    idle(); we = 1; wa = 0; wd = 8'hFF; step("wr_r0");
    idle(); iv = 1; ra = 0; rb = 0; step("rd_r0");
    chk("rd_r0_const", in_a, 8'h00);

    // immediate operand
    idle(); we = 1; wa = 1; wd = 8'h10; step("wr_r1");
    idle(); iv = 1; ra = 1; rb = 5; isel = 1; imm = 8'h06; step("imm");
    chk("imm_a_const", in_a, 8'h10);
    chk("imm_b_const", in_b, 8'h06);

    // flags capture and hold
    idle(); fe = 1; zi = 1; pi = 0; oi = 1; step("flag_set");
    chk("flag_set_const", 8'({zero, parity, odd}), 8'h05);
    idle(); fe = 0; zi = 0; pi = 1; oi = 0; step("flag_hold");
    chk("flag_hold_const", 8'({zero, parity, odd}), 8'h05);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 3) != 0);
      isel = ($urandom_range(0, 3) == 0);
      we   = 1'($urandom_range(0, 1));
      fe   = ($urandom_range(0, 3) == 0);
      zi   = 1'($urandom_range(0, 1));
      pi   = 1'($urandom_range(0, 1));
      oi   = 1'($urandom_range(0, 1));
      ra   = 3'($urandom_range(0, 7));
      rb   = 3'($urandom_range(0, 7));
      wa   = 3'($urandom_range(0, 7));
      imm  = 8'($urandom_range(0, 255));
      wd   = 8'($urandom_range(0, 255));
      step("rand");
    end

    // reset in the middle of a stall drops the pair and clears the file
    idle(); iv = 1; ra = 7; rb = 6; step("pre_rst_issue");
    idle(); ordy = 0; step("pre_rst_stall");
    reset_pulse("mid_stall_rst");
    for (int i = 1; i < 8; i++) begin
      idle(); iv = 1; ra = 3'(i); rb = 3'(i); step("post_rst_rd");
      chk("post_rst_a_zero", in_a, 8'h00);
      chk("post_rst_b_zero", in_b, 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
